// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format codes, RV32 opcode constants and skid-buffer states
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_format_decode.sv
// rtl/imm_format_decode.sv - combinational RV32 immediate extraction and sign extension to XLEN
module imm_format_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32   = 32'd0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                fmt   = FMT_I;
            end
            OP_STORE: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt   = FMT_S;
            end
            OP_BRANCH: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {instr[31:12], 12'd0};
                fmt   = FMT_U;
            end
            OP_JAL: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt   = FMT_J;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit form already carries instr[31] in bit 31, so widening just replicates it.
    always_comb begin
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - immediate decode stage with 2-entry skid buffer; IMMGEN_STATS_EN adds illegal_count
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
`ifdef IMMGEN_STATS_EN
    ,
    output logic [15:0]     illegal_count
`endif
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_format_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_e     state_q, state_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_imm_q, skid_imm_q;
    imm_fmt_e        out_fmt_q, skid_fmt_q;
    logic            out_ill_q, skid_ill_q;

    logic in_fire;
    logic out_fire;
    logic load_out_dec;
    logic load_out_skid;
    logic load_skid;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_ONE;
                    load_out_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_fire && !in_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire && out_fire) begin
                    load_out_dec = 1'b1;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over any transfer in the same cycle, including the word on the input.
        if (flush) begin
            state_d       = ST_EMPTY;
            load_out_dec  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_ill_q   <= 1'b0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            if (flush) begin
                out_imm_q <= '0;
                out_fmt_q <= FMT_NONE;
                out_ill_q <= 1'b0;
            end else if (load_out_dec) begin
                out_imm_q <= dec_imm;
                out_fmt_q <= dec_fmt;
                out_ill_q <= dec_illegal;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_fmt_q <= skid_fmt_q;
                out_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_fmt_q <= dec_fmt;
                skid_ill_q <= dec_illegal;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign fmt       = out_fmt_q;
    assign illegal   = out_ill_q;

`ifdef IMMGEN_STATS_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // Only reset clears the count; a flushed input word was never accepted.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (in_fire && !flush && dec_illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_cnt_q <= 16'd0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_count = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized and directed checks of imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;

    logic        in_ready, out_valid, illegal;
    logic [31:0] imm;
    imm_fmt_e    fmt;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    imm_fmt_e    fmt64;
`ifdef IMMGEN_STATS_EN
    logic [15:0] illegal_count, illegal_count64;
`endif

    imm_decode_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .fmt       (fmt),
        .illegal   (illegal)
`ifdef IMMGEN_STATS_EN
        ,
        .illegal_count (illegal_count)
`endif
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm       (imm64),
        .fmt       (fmt64),
        .illegal   (illegal64)
`ifdef IMMGEN_STATS_EN
        ,
        .illegal_count (illegal_count64)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q[$];
    int          ill_model = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_imm(input logic [31:0] w);
        longint v;
        case (w[6:0])
            OP_IMM, OP_LOAD, OP_JALR: v = $signed(w[31:20]);
            OP_STORE:                 v = $signed({w[31:25], w[11:7]});
            OP_BRANCH: begin
                v = $signed({w[31], w[7], w[30:25], w[11:8]});
                v = v * 2;
            end
            OP_LUI, OP_AUIPC: begin
                v = $signed(w[31:12]);
                v = v * 4096;
            end
            OP_JAL: begin
                v = $signed({w[31], w[19:12], w[20], w[30:21]});
                v = v * 2;
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic imm_fmt_e ref_fmt(input logic [31:0] w);
        case (w[6:0])
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction

    task automatic check_outputs();
        longint e;
        check_eq("in_ready", in_ready, q.size() < 2);
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("in_ready64", in_ready64, q.size() < 2);
        check_eq("out_valid64", out_valid64, q.size() > 0);
        if (q.size() > 0) begin
            e = ref_imm(q[0]);
            check_eq("imm32", imm, e[31:0]);
            check_eq("imm64", imm64, e);
            check_eq("fmt", fmt, ref_fmt(q[0]));
            check_eq("fmt64", fmt64, ref_fmt(q[0]));
            check_eq("illegal", illegal, ref_fmt(q[0]) == FMT_NONE);
            check_eq("illegal64", illegal64, ref_fmt(q[0]) == FMT_NONE);
        end
`ifdef IMMGEN_STATS_EN
        check_eq("illegal_count", illegal_count, ill_model);
        check_eq("illegal_count64", illegal_count64, ill_model);
`endif
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        bit acc_in, acc_out;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        instr     = w;
        out_ready = rdy;
        flush     = fl;
        acc_in  = v && (q.size() < 2);
        acc_out = rdy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in) begin
                q.push_back(w);
                if (ref_fmt(w) == FMT_NONE && ill_model < 16'hFFFF) ill_model++;
            end
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] exp_imm, input imm_fmt_e exp_fmt,
                               input logic exp_ill);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_imm"}, imm, exp_imm);
        check_eq({tag, "_fmt"}, fmt, exp_fmt);
        check_eq({tag, "_illegal"}, illegal, exp_ill);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        ops = '{OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, 7'h7F};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
        return w;
    endfunction

    logic [31:0] dir_instr [6];
    logic [31:0] dir_imm   [6];
    imm_fmt_e    dir_fmt   [6];

    initial begin
        dir_instr = '{32'hFFF00093, 32'hFE112E23, 32'h00000863, 32'h123452B7, 32'hFF9FF06F, 32'h0000007F};
        dir_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000010, 32'h12345000, 32'hFFFFFFF8, 32'h00000000};
        dir_fmt   = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_imm", imm, 32'd0);
        check_eq("rst_fmt", fmt, FMT_NONE);
        check_eq("rst_illegal", illegal, 1'b0);
`ifdef IMMGEN_STATS_EN
        check_eq("rst_illegal_count", illegal_count, 16'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(1'b1, dir_instr[i], 1'b1, 1'b0);
            expect_head($sformatf("dir%0d", i), dir_imm[i], dir_fmt[i], dir_fmt[i] == FMT_NONE);
            if (i == 0) check_eq("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end

        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h00000863, 1'b0, 1'b0);
        step(1'b1, 32'h00000863, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_imm_stable", imm, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst2_out_valid", out_valid, 1'b0);
        check_eq("rst2_in_ready", in_ready, 1'b1);
        check_eq("rst2_fmt", fmt, FMT_NONE);
        q.delete();
        ill_model = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);
        end

`ifdef IMMGEN_STATS_EN
        for (int i = 0; i < 65540; i++) step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("sat_illegal_count", illegal_count, 16'hFFFF);
`endif

        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
